i2c_txn_arbiter: RTL

Round-robin arbiter and sequencer that shares the single I2C master between N_REQ independent requesters (e.g. TramelBlaze port, button/switch path, test logic). It latches one requester's 7-bit address and 8-bit write data, issues a one-cycle start to the master, and waits for completion. It returns done/NACK status to the granted requester. A watchdog aborts transactions whose slave never acknowledges, so the bus cannot hang forever.

---
 rtl/i2c_txn_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master between N_REQ requesters.
// Latches address/data, pulses start, watches for done or watchdog expiry.
module i2c_txn_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [7*N_REQ-1:0] addr_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic [N_REQ-1:0]   done_o,
  output logic               nack_o,
  output logic               timeout_o,
  output logic               busy_o,
  output logic               m_start_o,
  output logic [6:0]         m_addr_o,
  output logic [7:0]         m_data_o,
  output logic               m_abort_o,
  input  logic               m_done_i,
  input  logic               m_nack_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    idx, idx_n;
  logic [IW-1:0]    sel;
  logic             found;
  logic [TW-1:0]    timer, timer_n;
  logic [N_REQ-1:0] grant_n, done_n;
  logic [6:0]       addr_n;
  logic [7:0]       data_n;
  logic             start_n, abort_n, nack_n, tmo_n;

  // Pick the first pending request at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && req_i[k]) begin
        found = 1'b1;
        sel   = IW'(k);
      end
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    timer_n = timer;
    grant_n = grant_o;
    addr_n  = m_addr_o;
    data_n  = m_data_o;
    done_n  = '0;
    start_n = 1'b0;
    abort_n = 1'b0;
    nack_n  = 1'b0;
    tmo_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n      = ISSUE;
          idx_n        = sel;
          grant_n      = '0;
          grant_n[sel] = 1'b1;
          addr_n       = addr_i[sel*7 +: 7];
          data_n       = data_i[sel*8 +: 8];
        end
      end
      ISSUE: begin
        start_n = 1'b1;
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        timer_n = timer + 1'b1;
        if (m_done_i) begin
          state_n = RESPOND;
          done_n  = grant_o;
          nack_n  = m_nack_i;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_n = RESPOND;
          done_n  = grant_o;
          abort_n = 1'b1;
          nack_n  = 1'b1;
          tmo_n   = 1'b1;
        end
      end
      RESPOND: begin
        grant_n = '0;
        ptr_n   = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      timer     <= '0;
      grant_o   <= '0;
      done_o    <= '0;
      nack_o    <= 1'b0;
      timeout_o <= 1'b0;
      m_start_o <= 1'b0;
      m_abort_o <= 1'b0;
      m_addr_o  <= '0;
      m_data_o  <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      idx       <= idx_n;
      timer     <= timer_n;
      grant_o   <= grant_n;
      done_o    <= done_n;
      nack_o    <= nack_n;
      timeout_o <= tmo_n;
      m_start_o <= start_n;
      m_abort_o <= abort_n;
      m_addr_o  <= addr_n;
      m_data_o  <= data_n;
    end
  end

  assign busy_o = (state != IDLE);

endmodule
